// File: rtl/gf163_result_collector.sv
// Receive end of the GF(2^163) multiplier stream: gathers NUM_WORDS product words
// per ctro burst and offers the extracted field element on a one-entry valid/ready port.
module gf163_result_collector #(
    parameter int unsigned WORD_W    = 32,
    parameter int unsigned NUM_WORDS = 6,
    parameter int unsigned FIELD_M   = 163,
    parameter int unsigned LSB_OFS   = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ctro,
    input  logic [WORD_W-1:0]  po,
    input  logic               res_ready,
    output logic               res_valid,
    output logic [FIELD_M-1:0] res_data,
    output logic               frag_err,
    output logic               ovr_err,
    output logic [CNT_W-1:0]   res_count,
    output logic               busy
);

    localparam int unsigned IMG_W = WORD_W * NUM_WORDS;
    localparam int unsigned WC_W  = $clog2(NUM_WORDS + 1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] DRAIN   = 2'd2;

    logic [1:0]       state;
    logic [WC_W-1:0]  word_cnt;
    logic [IMG_W-1:0] shift;
    logic [IMG_W-1:0] image;
    logic             complete;
    logic             consume;

    // image already includes the word being sampled, so completion needs no extra cycle
    always_comb begin
        image    = {shift[IMG_W-WORD_W-1:0], po};
        complete = (state == COLLECT) && ctro && (word_cnt == WC_W'(NUM_WORDS - 1));
        consume  = res_valid && res_ready;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            word_cnt <= '0;
            shift    <= '0;
            frag_err <= 1'b0;
        end else begin
            frag_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (ctro) begin
                        shift    <= IMG_W'(po);
                        word_cnt <= WC_W'(1);
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (ctro) begin
                        shift    <= image;
                        word_cnt <= word_cnt + 1'b1;
                        if (complete) begin
                            state <= DRAIN;
                        end
                    end else begin
                        word_cnt <= '0;
                        frag_err <= 1'b1;
                        state    <= IDLE;
                    end
                end
                DRAIN: begin
                    word_cnt <= '0;
                    if (!ctro) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state    <= IDLE;
                    word_cnt <= '0;
                end
            endcase
        end
    end

    // A consume on the completion edge frees the slot, so the new product is not an overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            ovr_err   <= 1'b0;
            res_count <= '0;
        end else begin
            if (consume) begin
                res_count <= res_count + 1'b1;
            end
            if (complete) begin
                if (!res_valid || res_ready) begin
                    res_data  <= image[LSB_OFS+FIELD_M-1:LSB_OFS];
                    res_valid <= 1'b1;
                end else begin
                    ovr_err <= 1'b1;
                end
            end else if (consume) begin
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_gf163_result_collector.sv
// Directed bench for gf163_result_collector: single product, backpressure/overrun,
// fragments, overlong bursts, consume-on-completion and mid-burst reset.
module tb_gf163_result_collector;

    logic         clk;
    logic         rst;
    logic         ctro;
    logic [31:0]  po;
    logic         res_ready;
    logic         res_valid;
    logic [162:0] res_data;
    logic         frag_err;
    logic         ovr_err;
    logic [15:0]  res_count;
    logic         busy;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0]  wq [0:8];
    logic [162:0] exp_a;
    logic [162:0] exp_b;

    gf163_result_collector #(
        .WORD_W(32),
        .NUM_WORDS(6),
        .FIELD_M(163),
        .LSB_OFS(5),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ctro(ctro),
        .po(po),
        .res_ready(res_ready),
        .res_valid(res_valid),
        .res_data(res_data),
        .frag_err(frag_err),
        .ovr_err(ovr_err),
        .res_count(res_count),
        .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [162:0] got, input logic [162:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the edge, inputs change there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        ctro = 1'b0;
        po   = '0;
        step();
        rst = 1'b0;
    endtask

    // Drives wq[0..n-1] on consecutive cycles with ctro high, leaving ctro high afterwards.
    task automatic send_words(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            ctro = 1'b1;
            po   = wq[i];
            step();
        end
    endtask

    task automatic idle_cycle();
        ctro = 1'b0;
        po   = '0;
        step();
    endtask

    function automatic logic [162:0] field_of_words();
        logic [191:0] img;
        img = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            img = {img[159:0], wq[i]};
        end
        return img[167:5];
    endfunction

    initial begin
        rst = 1'b0; ctro = 1'b0; po = '0; res_ready = 1'b0;
        #2;

        // Reset state
        do_reset();
        check("reset_valid", 163'(res_valid), 163'd0);
        check("reset_data", res_data, 163'd0);
        check("reset_count", 163'(res_count), 163'd0);
        check("reset_busy", 163'(busy), 163'd0);
        check("reset_ovr", 163'(ovr_err), 163'd0);

        // Single product: image = AB<<160 | 0x20 -> field = AB<<155 | 1
        res_ready = 1'b1;
        wq[0] = 32'h0000_00AB; wq[1] = '0; wq[2] = '0; wq[3] = '0; wq[4] = '0;
        wq[5] = 32'h0000_0020;
        send_words(5);
        check("single_not_early", 163'(res_valid), 163'd0);
        send_words(6 - 5 + 0 == 1 ? 0 : 0);
        ctro = 1'b1; po = wq[5]; step();
        check("single_valid", 163'(res_valid), 163'd1);
        check("single_data", res_data, (163'hAB << 155) | 163'd1);
        idle_cycle();
        check("single_valid_drop", 163'(res_valid), 163'd0);
        check("single_count", 163'(res_count), 163'd1);
        check("single_busy_idle", 163'(busy), 163'd0);

        // Backpressure: two bursts while res_ready=0
        do_reset();
        res_ready = 1'b0;
        wq[0] = 32'h1111_2222; wq[1] = 32'h3333_4444; wq[2] = 32'h5555_6666;
        wq[3] = 32'h7777_8888; wq[4] = 32'h9999_AAAA; wq[5] = 32'hBBBB_CCCC;
        exp_a = field_of_words();
        send_words(6);
        idle_cycle();
        check("bp_first_valid", 163'(res_valid), 163'd1);
        check("bp_first_data", res_data, exp_a);
        check("bp_no_ovr_yet", 163'(ovr_err), 163'd0);
        wq[0] = 32'hCAFE_0001; wq[1] = 32'hCAFE_0002; wq[2] = 32'hCAFE_0003;
        wq[3] = 32'hCAFE_0004; wq[4] = 32'hCAFE_0005; wq[5] = 32'hCAFE_0006;
        send_words(6);
        idle_cycle();
        check("bp_ovr", 163'(ovr_err), 163'd1);
        check("bp_held_data", res_data, exp_a);
        res_ready = 1'b1;
        step();
        check("bp_consumed", 163'(res_valid), 163'd0);
        check("bp_count", 163'(res_count), 163'd1);
        check("bp_ovr_sticky", 163'(ovr_err), 163'd1);

        // Fragment then all-ones burst
        do_reset();
        res_ready = 1'b0;
        for (int unsigned i = 0; i < 6; i++) wq[i] = 32'hFFFF_FFFF;
        send_words(4);
        idle_cycle();
        check("frag_pulse", 163'(frag_err), 163'd1);
        check("frag_no_valid", 163'(res_valid), 163'd0);
        idle_cycle();
        check("frag_pulse_end", 163'(frag_err), 163'd0);
        send_words(6);
        check("ones_valid", 163'(res_valid), 163'd1);
        check("ones_data", res_data, {163{1'b1}});
        idle_cycle();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // Overlong burst: words 7-9 must be ignored
        do_reset();
        wq[0] = 32'h0123_4567; wq[1] = 32'h89AB_CDEF; wq[2] = 32'h0F0F_F0F0;
        wq[3] = 32'h1357_9BDF; wq[4] = 32'h2468_ACE0; wq[5] = 32'h8000_0001;
        wq[6] = 32'hDEAD_BEEF; wq[7] = 32'hDEAD_BEEF; wq[8] = 32'hDEAD_BEEF;
        exp_a = field_of_words();
        send_words(9);
        check("long_busy", 163'(busy), 163'd1);
        check("long_data", res_data, exp_a);
        check("long_no_ovr", 163'(ovr_err), 163'd0);
        idle_cycle();
        check("long_busy_drop", 163'(busy), 163'd0);
        res_ready = 1'b1;
        step();
        check("long_one_result", 163'(res_count), 163'd1);
        check("long_valid_clear", 163'(res_valid), 163'd0);
        res_ready = 1'b0;

        // Consume on the completion edge
        do_reset();
        wq[0] = 32'hA5A5_A5A5; wq[1] = 32'h5A5A_5A5A; wq[2] = 32'h0000_FFFF;
        wq[3] = 32'hFFFF_0000; wq[4] = 32'h1234_5678; wq[5] = 32'h8765_4321;
        send_words(6);
        idle_cycle();
        wq[0] = 32'h0BAD_F00D; wq[1] = 32'hFEED_FACE; wq[2] = 32'h0000_0001;
        wq[3] = 32'h4000_0000; wq[4] = 32'h7FFF_FFFF; wq[5] = 32'hFFFF_FFE0;
        exp_b = field_of_words();
        send_words(5);
        res_ready = 1'b1;
        ctro = 1'b1; po = wq[5]; step();
        res_ready = 1'b0;
        check("sim_valid", 163'(res_valid), 163'd1);
        check("sim_data", res_data, exp_b);
        check("sim_no_ovr", 163'(ovr_err), 163'd0);
        check("sim_count", 163'(res_count), 163'd1);

        // Reset mid-burst with a result pending
        idle_cycle();
        send_words(3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        ctro = 1'b0;
        check("mid_rst_valid", 163'(res_valid), 163'd0);
        check("mid_rst_data", res_data, 163'd0);
        check("mid_rst_count", 163'(res_count), 163'd0);
        check("mid_rst_busy", 163'(busy), 163'd0);
        wq[0] = 32'h0000_0003; wq[1] = 32'h0000_0004; wq[2] = 32'h0000_0005;
        wq[3] = 32'h0000_0006; wq[4] = 32'h0000_0007; wq[5] = 32'h0000_0008;
        exp_a = field_of_words();
        send_words(6);
        check("post_rst_valid", 163'(res_valid), 163'd1);
        check("post_rst_data", res_data, exp_a);
        check("post_rst_count", 163'(res_count), 163'd0);
        check("post_rst_ovr", 163'(ovr_err), 163'd0);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
